// File: rtl/seg_pkg.sv
// seg_pkg: glyph table and segment bit positions shared by the 7-segment encoder and decoder
package seg_pkg;
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Active-high abcdefg patterns, index = hex value
   localparam logic [6:0] GLYPH [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };
   localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: classifies an active-low segment bus as hex glyph, blank or unknown
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [7:0] seg_n_i,
   output logic       known_o,
   output logic       blank_o,
   output logic [3:0] val_o,
   output logic       dp_o
);
   logic [6:0] abcdefg;

   assign abcdefg = ~seg_n_i[SEG_A:SEG_G];
   assign blank_o = abcdefg == GLYPH_BLANK;
   assign dp_o    = ~seg_n_i[SEG_DP];

   // Table lookup; glyphs are unique so at most one entry matches
   always_comb begin
      known_o = 1'b0;
      val_o   = 4'd0;
      for (int k = 0; k < 16; k++)
         if (abcdefg == GLYPH[k]) begin
            known_o = 1'b1;
            val_o   = k[3:0];
         end
   end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers per-digit hex value, ok flag and dp from a multiplexed 7-segment scan bus
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int STABLE_SCANS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIGITS-1:0]     an_n,
   input  logic [7:0]            seg_n,
   input  logic                  sample_en,
   input  logic                  err_clr,
   output logic [4*DIGITS-1:0]   digit_val,
   output logic [DIGITS-1:0]     digit_ok,
   output logic [DIGITS-1:0]     dp_out,
   output logic                  upd,
   output logic                  err_sel,
   output logic                  err_pat
);
   localparam int CW = $clog2(STABLE_SCANS + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] SAT = CW'(STABLE_SCANS);

   logic              known, blank, dp;
   logic [3:0]        val;
   logic [DIGITS-1:0] sel;
   logic              multi, hit;
   logic [IW-1:0]     idx;
   logic [5:0]        cand;

   logic [5:0]          cand_q [DIGITS];
   logic [5:0]          cand_d [DIGITS];
   logic [CW-1:0]       cnt_q  [DIGITS];
   logic [CW-1:0]       cnt_d  [DIGITS];
   logic [4*DIGITS-1:0] val_q, val_d;
   logic [DIGITS-1:0]   ok_q, ok_d, dp_q, dp_d;
   logic                upd_q, upd_d, err_sel_q, err_sel_d, err_pat_q, err_pat_d;

   seg_pattern_decode u_dec (
      .seg_n_i (seg_n),
      .known_o (known),
      .blank_o (blank),
      .val_o   (val),
      .dp_o    (dp)
   );

   assign sel   = ~an_n;
   assign multi = (sel & (sel - 1'b1)) != '0;
   assign hit   = sample_en && sel != '0 && !multi;
   assign cand  = {known, known ? val : 4'd0, dp};

   // Selected digit index; only meaningful when exactly one enable is active
   always_comb begin
      idx = '0;
      for (int k = 0; k < DIGITS; k++)
         if (sel[k]) idx = IW'(k);
   end

   // Stability tracking, commit of stable candidates, change pulse and sticky errors
   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      val_d     = val_q;
      ok_d      = ok_q;
      dp_d      = dp_q;
      if (hit) begin
         if (cand == cand_q[idx])
            cnt_d[idx] = (cnt_q[idx] == SAT) ? cnt_q[idx] : cnt_q[idx] + 1'b1;
         else begin
            cand_d[idx] = cand;
            cnt_d[idx]  = CW'(1);
         end
         if (cnt_d[idx] == SAT) begin
            val_d[4*idx +: 4] = cand[4:1];
            ok_d[idx]         = cand[5];
            dp_d[idx]         = cand[0];
         end
      end
      upd_d     = {val_d, ok_d, dp_d} != {val_q, ok_q, dp_q};
      err_sel_d = (sample_en && multi) ? 1'b1 : err_clr ? 1'b0 : err_sel_q;
      err_pat_d = (hit && !known && !blank) ? 1'b1 : err_clr ? 1'b0 : err_pat_q;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_q    <= '{default: '0};
         cnt_q     <= '{default: '0};
         val_q     <= '0;
         ok_q      <= '0;
         dp_q      <= '0;
         upd_q     <= 1'b0;
         err_sel_q <= 1'b0;
         err_pat_q <= 1'b0;
      end else begin
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         val_q     <= val_d;
         ok_q      <= ok_d;
         dp_q      <= dp_d;
         upd_q     <= upd_d;
         err_sel_q <= err_sel_d;
         err_pat_q <= err_pat_d;
      end
   end

   assign digit_val = val_q;
   assign digit_ok  = ok_q;
   assign dp_out    = dp_q;
   assign upd       = upd_q;
   assign err_sel   = err_sel_q;
   assign err_pat   = err_pat_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  an_n = 8'hFF;
   logic [7:0]  seg_n = 8'hFF;
   logic        sample_en = 1'b0;
   logic        err_clr = 1'b0;
   logic [31:0] digit_val;
   logic [7:0]  digit_ok, dp_out;
   logic        upd, err_sel, err_pat;
   int          checks = 0;
   int          failures = 0;

   seg_scan_decoder #(.DIGITS(8), .STABLE_SCANS(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .an_n      (an_n),
      .seg_n     (seg_n),
      .sample_en (sample_en),
      .err_clr   (err_clr),
      .digit_val (digit_val),
      .digit_ok  (digit_ok),
      .dp_out    (dp_out),
      .upd       (upd),
      .err_sel   (err_sel),
      .err_pat   (err_pat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic smp(input logic [7:0] a, input logic [7:0] s);
      an_n = a;
      seg_n = s;
      sample_en = 1'b1;
      @(posedge clk);
      #1;
      sample_en = 1'b0;
      an_n = 8'hFF;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_val", digit_val, 32'h0);
      chk("rst_ok", digit_ok, 8'h00);
      chk("rst_dp", dp_out, 8'h00);
      chk("rst_flags", {29'b0, upd, err_sel, err_pat}, 32'h0);
      rst_n = 1'b1;
      idle();

      smp(8'hFB, 8'h0D);
      chk("d2_first_val", digit_val, 32'h0);
      chk("d2_first_upd", upd, 1'b0);
      smp(8'hFB, 8'h0D);
      chk("d2_val", digit_val, 32'h0000_0300);
      chk("d2_ok", digit_ok, 8'h04);
      chk("d2_upd", upd, 1'b1);
      idle();
      chk("d2_upd_drop", upd, 1'b0);

      smp(8'hFE, 8'h11);
      chk("d0_a_val", digit_val, 32'h0000_0300);
      smp(8'hFE, 8'h0D);
      chk("d0_3a_val", digit_val, 32'h0000_0300);
      chk("d0_3a_upd", upd, 1'b0);
      smp(8'hFE, 8'h0D);
      chk("d0_val", digit_val, 32'h0000_0303);
      chk("d0_ok", digit_ok, 8'h05);
      chk("d0_upd", upd, 1'b1);

      smp(8'h7F, 8'h00);
      smp(8'h7F, 8'h00);
      chk("d7_val", digit_val, 32'h8000_0303);
      chk("d7_dp", dp_out, 8'h80);
      chk("d7_ok", digit_ok, 8'h85);
      chk("d7_upd", upd, 1'b1);
      smp(8'h7F, 8'h00);
      chk("d7_rep1_upd", upd, 1'b0);
      smp(8'h7F, 8'h00);
      chk("d7_rep2_upd", upd, 1'b0);
      chk("d7_rep_val", digit_val, 32'h8000_0303);

      smp(8'hFD, 8'hFD);
      chk("d1_pat_err", err_pat, 1'b1);
      smp(8'hFD, 8'hFD);
      chk("d1_ok", digit_ok, 8'h85);
      chk("d1_val", digit_val, 32'h8000_0303);
      chk("d1_upd", upd, 1'b0);
      err_clr = 1'b1;
      idle();
      err_clr = 1'b0;
      chk("pat_clr", err_pat, 1'b0);
      err_clr = 1'b1;
      smp(8'hFD, 8'hFD);
      err_clr = 1'b0;
      chk("pat_set_wins", err_pat, 1'b1);

      smp(8'hFC, 8'h49);
      chk("sel_err", err_sel, 1'b1);
      smp(8'hFC, 8'h49);
      chk("sel_val", digit_val, 32'h8000_0303);
      chk("sel_upd", upd, 1'b0);
      err_clr = 1'b1;
      idle();
      err_clr = 1'b0;
      chk("errs_clr", {err_sel, err_pat}, 2'b00);
      smp(8'hFF, 8'h49);
      smp(8'hFF, 8'h49);
      chk("blank_errs", {err_sel, err_pat}, 2'b00);
      chk("blank_val", digit_val, 32'h8000_0303);
      chk("blank_upd", upd, 1'b0);

      smp(8'hEF, 8'h49);
      chk("d4_partial", digit_val, 32'h8000_0303);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      chk("mid_rst_val", digit_val, 32'h0);
      chk("mid_rst_bits", {digit_ok, dp_out}, 16'h0);
      smp(8'hEF, 8'h49);
      chk("post_rst_val", digit_val, 32'h0);
      chk("post_rst_upd", upd, 1'b0);
      smp(8'hEF, 8'h49);
      chk("d4_val", digit_val, 32'h0005_0000);
      chk("d4_ok", digit_ok, 8'h10);
      chk("d4_upd", upd, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
